// File: rtl/mu_bus_arbiter.sv
// mu_bus_arbiter: shares the single MemoryUnit request port between the CPU
// and a second bus master (DMA/blitter). Each master gets a one-deep request
// latch and a private busy/q pair; requests are serialised onto the
// MemoryUnit start/busy handshake by a three-state FSM.
module mu_bus_arbiter #(
  parameter int ADDR_W       = 27,
  parameter int DATA_W       = 32,
  parameter int CPU_PRIORITY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mu_init_done,
  input  logic              cpu_start,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              cpu_we,
  output logic              cpu_busy,
  output logic [DATA_W-1:0] cpu_q,
  input  logic              dma_start,
  input  logic [ADDR_W-1:0] dma_address,
  input  logic [DATA_W-1:0] dma_data,
  input  logic              dma_we,
  output logic              dma_busy,
  output logic [DATA_W-1:0] dma_q,
  output logic              mu_start,
  output logic [ADDR_W-1:0] mu_address,
  output logic [DATA_W-1:0] mu_data,
  output logic              mu_we,
  input  logic              mu_busy,
  input  logic [DATA_W-1:0] mu_q,
  output logic              grant_dma
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_mu_start;
  logic [ADDR_W-1:0] r_mu_address;
  logic [DATA_W-1:0] r_mu_data;
  logic              r_mu_we;
  logic              r_grant_dma;
  logic [3:0]        r_starve_cnt;
  logic              r_settle;
  logic              r_init_done;

  // Master 0 is the CPU, master 1 the DMA; both share one latch template.
  logic              w_start    [2];
  logic [ADDR_W-1:0] w_addr     [2];
  logic [DATA_W-1:0] w_data     [2];
  logic              w_we       [2];
  logic              w_owner    [2];
  logic [1:0]        w_pend;
  logic [ADDR_W-1:0] w_lat_addr [2];
  logic [DATA_W-1:0] w_lat_data [2];
  logic              w_lat_we   [2];
  logic [DATA_W-1:0] w_q        [2];
  logic              w_pick_dma;
  logic              w_decide;
  logic              w_done;

  assign w_start[0] = cpu_start;
  assign w_start[1] = dma_start;
  assign w_addr[0]  = cpu_address;
  assign w_addr[1]  = dma_address;
  assign w_data[0]  = cpu_data;
  assign w_data[1]  = dma_data;
  assign w_we[0]    = cpu_we;
  assign w_we[1]    = dma_we;
  assign w_owner[0] = ~r_grant_dma;
  assign w_owner[1] = r_grant_dma;

  // A grant decision is taken in IDLE only; the cycle right after a
  // completion is skipped so that the just-served master, whose re-request
  // is accepted as its busy drops, competes in the decision.
  assign w_decide = (r_state == ST_IDLE) & r_init_done & ~r_settle & (|w_pend);
  assign w_done   = (r_state == ST_WAIT) & ~mu_busy;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      logic              r_pend;
      logic [ADDR_W-1:0] r_addr;
      logic [DATA_W-1:0] r_data;
      logic              r_we;
      logic [DATA_W-1:0] r_q;

      // Request latch: capture when idle, release when its transaction completes
      always_ff @(posedge clk) begin
        if (reset) begin
          r_pend <= 1'b0;
          r_addr <= '0;
          r_data <= '0;
          r_we   <= 1'b0;
        end else if (w_done && w_owner[gi]) begin
          r_pend <= 1'b0;
        end else if (w_start[gi] && !r_pend) begin
          r_pend <= 1'b1;
          r_addr <= w_addr[gi];
          r_data <= w_data[gi];
          r_we   <= w_we[gi];
        end
      end

      // Result register, held until this master's next completion
      always_ff @(posedge clk) begin
        if (reset) begin
          r_q <= '0;
        end else if (w_done && w_owner[gi]) begin
          r_q <= mu_q;
        end
      end

      assign w_pend[gi]     = r_pend;
      assign w_lat_addr[gi] = r_addr;
      assign w_lat_data[gi] = r_data;
      assign w_lat_we[gi]   = r_we;
      assign w_q[gi]        = r_q;
    end
  endgenerate

  // Winner selection: priority-with-starvation-guard or alternating
  always_comb begin
    w_pick_dma = 1'b0;
    if (CPU_PRIORITY != 0) begin
      w_pick_dma = w_pend[1] & (~w_pend[0] | (r_starve_cnt == LP_LIMIT));
    end else begin
      w_pick_dma = w_pend[1] & (~w_pend[0] | ~r_grant_dma);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_decide) w_state_next = ST_ISSUE;
      ST_ISSUE: if (mu_busy)  w_state_next = ST_WAIT;
      ST_WAIT:  if (!mu_busy) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Registered MemoryUnit request; fields load only on a grant decision
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mu_start   <= 1'b0;
      r_mu_address <= '0;
      r_mu_data    <= '0;
      r_mu_we      <= 1'b0;
      r_grant_dma  <= 1'b0;
    end else begin
      r_mu_start <= (w_state_next == ST_ISSUE);
      if (w_decide) begin
        r_grant_dma  <= w_pick_dma;
        r_mu_address <= w_lat_addr[w_pick_dma];
        r_mu_data    <= w_lat_data[w_pick_dma];
        r_mu_we      <= w_lat_we[w_pick_dma];
      end
    end
  end

  // Count CPU grants that overtake a waiting DMA request, saturating
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= 4'd0;
    end else if (!w_pend[1]) begin
      r_starve_cnt <= 4'd0;
    end else if (w_decide) begin
      if (w_pick_dma) begin
        r_starve_cnt <= 4'd0;
      end else if (r_starve_cnt != LP_LIMIT) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

  // Post-completion hold flag and registered init-done qualifier
  always_ff @(posedge clk) begin
    if (reset) begin
      r_settle    <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_settle    <= w_done;
      r_init_done <= mu_init_done;
    end
  end

  assign cpu_busy   = w_pend[0];
  assign dma_busy   = w_pend[1];
  assign cpu_q      = w_q[0];
  assign dma_q      = w_q[1];
  assign mu_start   = r_mu_start;
  assign mu_address = r_mu_address;
  assign mu_data    = r_mu_data;
  assign mu_we      = r_mu_we;
  assign grant_dma  = r_grant_dma;

endmodule

// File: tb/tb_mu_bus_arbiter.sv
// Testbench for mu_bus_arbiter: instance 0 uses CPU priority with a
// starvation limit of 4, instance 1 uses round-robin. A small MemoryUnit
// model answers each instance; instance 0 can instead be driven directly
// from the vector table.
`timescale 1ns/1ps
module tb_mu_bus_arbiter;
  localparam int AW = 27;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          init_done;
  logic          cpu_start, cpu_we, dma_start, dma_we;
  logic [AW-1:0] cpu_address, dma_address;
  logic [DW-1:0] cpu_data, dma_data;

  logic          model_en;
  logic          tv_busy;
  logic [DW-1:0] tv_q;
  int            lat;
  logic          m_busy [2];
  logic [DW-1:0] m_q    [2];
  int            m_cnt  [2];
  logic          in_busy [2];
  logic [DW-1:0] in_q    [2];

  logic          o_cpu_busy [2];
  logic [DW-1:0] o_cpu_q    [2];
  logic          o_dma_busy [2];
  logic [DW-1:0] o_dma_q    [2];
  logic          o_mu_start [2];
  logic [AW-1:0] o_mu_addr  [2];
  logic [DW-1:0] o_mu_data  [2];
  logic          o_mu_we    [2];
  logic          o_grant    [2];

  assign in_busy[0] = model_en ? m_busy[0] : tv_busy;
  assign in_q[0]    = model_en ? m_q[0] : tv_q;
  assign in_busy[1] = m_busy[1];
  assign in_q[1]    = m_q[1];

  mu_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CPU_PRIORITY(1), .STARVE_LIMIT(4)) u_prio (
    .clk(clk), .reset(reset), .mu_init_done(init_done),
    .cpu_start(cpu_start), .cpu_address(cpu_address), .cpu_data(cpu_data), .cpu_we(cpu_we),
    .cpu_busy(o_cpu_busy[0]), .cpu_q(o_cpu_q[0]),
    .dma_start(dma_start), .dma_address(dma_address), .dma_data(dma_data), .dma_we(dma_we),
    .dma_busy(o_dma_busy[0]), .dma_q(o_dma_q[0]),
    .mu_start(o_mu_start[0]), .mu_address(o_mu_addr[0]), .mu_data(o_mu_data[0]), .mu_we(o_mu_we[0]),
    .mu_busy(in_busy[0]), .mu_q(in_q[0]), .grant_dma(o_grant[0])
  );

  mu_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CPU_PRIORITY(0), .STARVE_LIMIT(4)) u_rr (
    .clk(clk), .reset(reset), .mu_init_done(init_done),
    .cpu_start(cpu_start), .cpu_address(cpu_address), .cpu_data(cpu_data), .cpu_we(cpu_we),
    .cpu_busy(o_cpu_busy[1]), .cpu_q(o_cpu_q[1]),
    .dma_start(dma_start), .dma_address(dma_address), .dma_data(dma_data), .dma_we(dma_we),
    .dma_busy(o_dma_busy[1]), .dma_q(o_dma_q[1]),
    .mu_start(o_mu_start[1]), .mu_address(o_mu_addr[1]), .mu_data(o_mu_data[1]), .mu_we(o_mu_we[1]),
    .mu_busy(in_busy[1]), .mu_q(in_q[1]), .grant_dma(o_grant[1])
  );

  // Read data the MemoryUnit model returns for a given address
  function automatic logic [DW-1:0] mq(input logic [AW-1:0] a);
    return {5'b0, a} ^ 32'hA5C3_0000;
  endfunction

  // MemoryUnit model: accepts mu_start when idle, stays busy for lat cycles
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_busy[i] <= 1'b0;
        m_cnt[i]  <= 0;
        m_q[i]    <= '0;
      end else if (!m_busy[i] && o_mu_start[i]) begin
        m_busy[i] <= 1'b1;
        m_cnt[i]  <= lat;
        m_q[i]    <= mq(o_mu_addr[i]);
      end else if (m_busy[i]) begin
        if (m_cnt[i] <= 1) m_busy[i] <= 1'b0;
        else m_cnt[i] <= m_cnt[i] - 1;
      end
    end
  end

  int checks   = 0;
  int failures = 0;
  int g_log [8];
  int g_n;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cpu_start = 1'b0; cpu_we = 1'b0; cpu_address = '0; cpu_data = '0;
    dma_start = 1'b0; dma_we = 1'b0; dma_address = '0; dma_data = '0;
    tv_busy = 1'b0; tv_q = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".mu_start"},  32'(o_mu_start[0]), 32'd0);
    chk({tag, ".mu_addr"},   32'(o_mu_addr[0]),  32'd0);
    chk({tag, ".mu_data"},   o_mu_data[0],       32'd0);
    chk({tag, ".mu_we"},     32'(o_mu_we[0]),    32'd0);
    chk({tag, ".cpu_busy"},  32'(o_cpu_busy[0]), 32'd0);
    chk({tag, ".dma_busy"},  32'(o_dma_busy[0]), 32'd0);
    chk({tag, ".cpu_q"},     o_cpu_q[0],         32'd0);
    chk({tag, ".dma_q"},     o_dma_q[0],         32'd0);
    chk({tag, ".grant_dma"}, 32'(o_grant[0]),    32'd0);
  endtask

  // Record the owner of each new transaction (rising mu_start) on instance k
  task automatic collect(input int k, input int n, input int budget);
    logic prev;
    for (int j = 0; j < 8; j++) g_log[j] = -1;
    g_n  = 0;
    prev = o_mu_start[k];
    for (int c = 0; c < budget && g_n < n; c++) begin
      step();
      if (o_mu_start[k] && !prev) begin
        g_log[g_n] = int'(o_grant[k]);
        $display("inst%0d transaction %0d owner=%s addr=0x%07h", k, g_n,
                 o_grant[k] ? "dma" : "cpu", o_mu_addr[k]);
        g_n++;
      end
      prev = o_mu_start[k];
    end
    chk($sformatf("collect%0d.count", k), 32'(g_n), 32'(n));
  endtask

  task automatic wait_idle(input int k, input int budget);
    int c;
    c = 0;
    while ((o_cpu_busy[k] || o_dma_busy[k]) && c < budget) begin
      step();
      c++;
    end
    chk($sformatf("wait_idle%0d.timeout", k), 32'(o_cpu_busy[k] | o_dma_busy[k]), 32'd0);
  endtask

  typedef struct {
    logic          cs;
    logic [AW-1:0] ca;
    logic          ds;
    logic [AW-1:0] da;
    logic [DW-1:0] dd;
    logic          dw;
    logic          busy;
    logic [DW-1:0] q;
    logic          e_start;
    logic          e_cbusy;
    logic          e_dbusy;
    logic [DW-1:0] e_cq;
    logic [DW-1:0] e_dq;
    logic          e_grant;
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t tv [12];
  int   exp_seq [6];
  logic seen;

  initial begin
    // cs ca ds da dd dw busy q | start cbusy dbusy cq dq grant addr we data
    tv[0]  = '{1'b1, 27'h0000123, 1'b0, 27'h0, 32'h0, 1'b0, 1'b0, 32'h0,
               1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 27'h0, 1'b0, 32'h0};
    tv[1]  = '{1'b0, 27'h0, 1'b0, 27'h0, 32'h0, 1'b0, 1'b0, 32'h0,
               1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 27'h0000123, 1'b0, 32'h0};
    tv[2]  = '{1'b0, 27'h0, 1'b0, 27'h0, 32'h0, 1'b0, 1'b0, 32'h0,
               1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 27'h0000123, 1'b0, 32'h0};
    tv[3]  = '{1'b0, 27'h0, 1'b0, 27'h0, 32'h0, 1'b0, 1'b1, 32'h0,
               1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 27'h0000123, 1'b0, 32'h0};
    tv[4]  = '{1'b0, 27'h0, 1'b0, 27'h0, 32'h0, 1'b0, 1'b1, 32'h0,
               1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 27'h0000123, 1'b0, 32'h0};
    tv[5]  = '{1'b0, 27'h0, 1'b0, 27'h0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF,
               1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 27'h0000123, 1'b0, 32'h0};
    tv[6]  = '{1'b0, 27'h0, 1'b0, 27'h0, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF,
               1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 27'h0000123, 1'b0, 32'h0};
    tv[7]  = '{1'b0, 27'h0, 1'b0, 27'h0, 32'h0, 1'b0, 1'b0, 32'h0,
               1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 27'h0000123, 1'b0, 32'h0};
    tv[8]  = '{1'b0, 27'h0, 1'b1, 27'h7FFFFFF, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0,
               1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0, 27'h0000123, 1'b0, 32'h0};
    tv[9]  = '{1'b0, 27'h0, 1'b0, 27'h0, 32'h0, 1'b0, 1'b0, 32'h0,
               1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0, 1'b1, 27'h7FFFFFF, 1'b1, 32'hCAFEF00D};
    tv[10] = '{1'b0, 27'h0, 1'b0, 27'h0, 32'h0, 1'b0, 1'b1, 32'h0,
               1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0, 1'b1, 27'h7FFFFFF, 1'b1, 32'hCAFEF00D};
    tv[11] = '{1'b0, 27'h0, 1'b0, 27'h0, 32'h0, 1'b0, 1'b0, 32'h12345678,
               1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h12345678, 1'b1, 27'h7FFFFFF, 1'b1, 32'hCAFEF00D};

    lat       = 2;
    model_en  = 1'b0;
    init_done = 1'b1;
    reset     = 1'b1;
    clear_inputs();

    // Reset state, then the CPU read / DMA write vector table
    do_reset();
    chk_reset_state("reset");
    step();
    for (int i = 0; i < 12; i++) begin
      cpu_start = tv[i].cs; cpu_address = tv[i].ca;
      dma_start = tv[i].ds; dma_address = tv[i].da; dma_data = tv[i].dd; dma_we = tv[i].dw;
      tv_busy   = tv[i].busy; tv_q = tv[i].q;
      step();
      chk($sformatf("v%0d.mu_start", i),  32'(o_mu_start[0]), 32'(tv[i].e_start));
      chk($sformatf("v%0d.cpu_busy", i),  32'(o_cpu_busy[0]), 32'(tv[i].e_cbusy));
      chk($sformatf("v%0d.dma_busy", i),  32'(o_dma_busy[0]), 32'(tv[i].e_dbusy));
      chk($sformatf("v%0d.cpu_q", i),     o_cpu_q[0],         tv[i].e_cq);
      chk($sformatf("v%0d.dma_q", i),     o_dma_q[0],         tv[i].e_dq);
      chk($sformatf("v%0d.grant_dma", i), 32'(o_grant[0]),    32'(tv[i].e_grant));
      chk($sformatf("v%0d.mu_addr", i),   32'(o_mu_addr[0]),  32'(tv[i].e_addr));
      chk($sformatf("v%0d.mu_we", i),     32'(o_mu_we[0]),    32'(tv[i].e_we));
      chk($sformatf("v%0d.mu_data", i),   o_mu_data[0],       tv[i].e_data);
    end
    clear_inputs();

    // Simultaneous starts with CPU priority: CPU first, then DMA
    model_en = 1'b1;
    lat      = 2;
    do_reset();
    step();
    cpu_start = 1'b1; cpu_address = 27'h00ABCDE;
    dma_start = 1'b1; dma_address = 27'h1000040;
    step();
    cpu_start = 1'b0; dma_start = 1'b0;
    chk("both.cpu_busy", 32'(o_cpu_busy[0]), 32'd1);
    chk("both.dma_busy", 32'(o_dma_busy[0]), 32'd1);
    collect(0, 2, 60);
    chk("both.first",  32'(g_log[0]), 32'd0);
    chk("both.second", 32'(g_log[1]), 32'd1);
    wait_idle(0, 60);
    chk("both.cpu_q", o_cpu_q[0], mq(27'h00ABCDE));
    chk("both.dma_q", o_dma_q[0], mq(27'h1000040));

    // Starvation guard: CPU re-requests continuously while DMA waits
    lat = 1;
    do_reset();
    step();
    cpu_start = 1'b1; cpu_address = 27'h0000200;
    dma_start = 1'b1; dma_address = 27'h0000300;
    step();
    dma_start = 1'b0;
    exp_seq = '{0, 0, 0, 0, 1, 0};
    collect(0, 6, 200);
    for (int i = 0; i < 6; i++) chk($sformatf("starve.g%0d", i), 32'(g_log[i]), 32'(exp_seq[i]));
    cpu_start = 1'b0;
    wait_idle(0, 60);
    chk("starve.dma_q", o_dma_q[0], mq(27'h0000300));

    // Round-robin: both masters re-request continuously
    do_reset();
    step();
    cpu_start = 1'b1; cpu_address = 27'h0000400;
    step();
    dma_start = 1'b1; dma_address = 27'h0000500;
    exp_seq = '{0, 1, 0, 1, 0, 1};
    collect(1, 6, 300);
    for (int i = 0; i < 6; i++) chk($sformatf("rr.g%0d", i), 32'(g_log[i]), 32'(exp_seq[i]));
    cpu_start = 1'b0; dma_start = 1'b0;
    wait_idle(1, 60);

    // Grants blocked until the MemoryUnit reports init done
    init_done = 1'b0;
    do_reset();
    step();
    cpu_start = 1'b1; cpu_address = 27'h0000055; cpu_data = 32'hA1B2C3D4; cpu_we = 1'b1;
    step();
    cpu_start = 1'b0; cpu_we = 1'b0; cpu_data = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("init%0d.mu_start", i), 32'(o_mu_start[0]), 32'd0);
      chk($sformatf("init%0d.cpu_busy", i), 32'(o_cpu_busy[0]), 32'd1);
    end
    init_done = 1'b1;
    step();
    chk("init.r1_mu_start", 32'(o_mu_start[0]), 32'd0);
    step();
    chk("init.r2_mu_start", 32'(o_mu_start[0]), 32'd1);
    chk("init.mu_we",       32'(o_mu_we[0]),    32'd1);
    chk("init.mu_data",     o_mu_data[0],       32'hA1B2C3D4);
    chk("init.mu_addr",     32'(o_mu_addr[0]),  32'h55);
    wait_idle(0, 60);

    // Reset during WAIT aborts the transaction; a later DMA read completes
    lat = 6;
    do_reset();
    step();
    cpu_start = 1'b1; cpu_address = 27'h0000066;
    step();
    cpu_start = 1'b0;
    wait_idle(0, 60);
    chk("abort.pre_cpu_q", o_cpu_q[0], mq(27'h0000066));
    cpu_start = 1'b1; cpu_address = 27'h0000077;
    step();
    cpu_start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (o_mu_start[0]) seen = 1'b1;
      else if (seen) break;
    end
    chk("abort.reached_wait", 32'(seen & ~o_mu_start[0] & o_cpu_busy[0]), 32'd1);
    reset = 1'b1;
    step();
    chk_reset_state("abort");
    reset = 1'b0;
    dma_start = 1'b1; dma_address = 27'h0000088;
    step();
    dma_start = 1'b0;
    wait_idle(0, 60);
    chk("abort.dma_q",     o_dma_q[0],         mq(27'h0000088));
    chk("abort.grant_dma", 32'(o_grant[0]),    32'd1);
    chk("abort.cpu_q",     o_cpu_q[0],         32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mu_bus_arbiter.md
# mu_bus_arbiter

Two-master arbiter that shares the single MemoryUnit request port (address/data/we/start/busy/q) between the CPU and a second bus master (DMA/blitter). It sits between `CPU`/DMA and `MemoryUnit` in the FPGC4 top level. It latches one request per master and serialises them onto the MemoryUnit handshake. Each master sees a private busy/q pair.

## Interface
- `ADDR_W`, 27, address width
- `DATA_W`, 32, data width
- `CPU_PRIORITY`, 1, 1 = CPU wins ties with DMA starvation guard; 0 = strict round-robin
- `STARVE_LIMIT`, 4, consecutive CPU grants allowed while DMA pending (CPU_PRIORITY=1 only), range 1..15

Ports:
- `clk` in 1 system clock (25 MHz domain shared with MemoryUnit)
- `reset` in 1 synchronous, active-high
- `mu_init_done` in 1 MemoryUnit initialisation complete
- `cpu_start` in 1 one-cycle request pulse
- `cpu_address` in ADDR_W, CPU request address
- `cpu_data` in DATA_W, CPU write data
- `cpu_we` in 1, CPU write enable
- `cpu_busy` out 1, CPU request pending or in service
- `cpu_q` out DATA_W, CPU read result
- `dma_start`, `dma_address`, `dma_data`, `dma_we`, `dma_busy`, `dma_q`: same as the cpu_* ports, for the DMA master
- `mu_start` out 1, request to MemoryUnit
- `mu_address` out ADDR_W, `mu_data` out DATA_W, `mu_we` out 1: registered request fields
- `mu_busy` in 1, MemoryUnit busy
- `mu_q` in DATA_W, MemoryUnit read data
- `grant_dma` out 1, current/last transaction owner (1 = DMA), for debug

## Operation
- Per-master request latch: `X_start` sampled high while `X_busy`=0 sets `pend_X` and captures address/data/we. `X_start` while `X_busy`=1 is ignored. `X_busy` = `pend_X`.
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE:**
  - If `mu_init_done`=1 and any `pend_X`: select the winner, load `mu_address`/`mu_data`/`mu_we` from its latch, set `grant_dma`, and go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE:**
  - `mu_start`=1.
  - Stay until `mu_busy`=1 is sampled, then go to WAIT with `mu_start`=0 on that next cycle.
- **WAIT:**
  - Stay while `mu_busy`=1.
  - On `mu_busy`=0: capture `mu_q` into the winner's `X_q`, clear the winner's `pend_X`, and go to IDLE.
- Selection with CPU_PRIORITY=1:
  - CPU wins if both are pending, unless `starve_cnt` = STARVE_LIMIT, in which case DMA wins.
  - `starve_cnt` increments on each CPU grant while `pend_dma`=1.
  - `starve_cnt` clears on a DMA grant or whenever `pend_dma`=0.
  - `starve_cnt` saturates at STARVE_LIMIT.
- Selection with CPU_PRIORITY=0: if both are pending, the master not granted last wins. `grant_dma` is the "last" marker.
- With one master pending, that master wins in either mode.
- `X_q` holds its value until that master's next completion; it is not cleared by a new request.
- Writes also update `X_q` with `mu_q`; masters ignore it.
- A new `X_start` from the just-completed master is accepted on the cycle `X_busy` is low. It competes in the next IDLE decision.

## Timing
- Reset values:
  - State IDLE.
  - `mu_start`=0, `mu_address`=0, `mu_data`=0, `mu_we`=0.
  - `cpu_busy`=`dma_busy`=0, `cpu_q`=`dma_q`=0.
  - `grant_dma`=0, `starve_cnt`=0, pend flags 0.
- Reset asserted mid-transaction aborts it: all of the above apply on the next edge. The MemoryUnit shares the same reset.
- Uncontended request, with start pulse at cycle T:
  - T+1: `X_busy`=1.
  - T+2: ISSUE, `mu_start`=1.
  - First `mu_busy`=1 sampled at cycle S: `mu_start`=0 from S+1.
  - `mu_busy`=0 sampled at cycle E: at E+1, `X_q` is valid and `X_busy`=0, both in the same cycle.
- Arbiter overhead: 2 cycles before issue, 1 cycle after completion. Back-to-back grants are separated by at least one IDLE cycle.
- Both masters pulsing start in the same cycle are both latched. The loser stays pending with `X_busy`=1.
- `mu_address`/`mu_data`/`mu_we` are stable from ISSUE entry until the next IDLE decision.
- `mu_init_done`=0 blocks grants only. Requests are still latched.

## Test plan
- Reset, then a CPU read at 0x0000123 while `mu_busy` is held high for 3 cycles and `mu_q`=0xDEADBEEF → `mu_start` is high exactly from T+2 until `mu_busy` is seen; `cpu_q`=0xDEADBEEF and `cpu_busy` falls at E+1; `dma_busy` stays 0.
- CPU and DMA start in the same cycle, CPU_PRIORITY=1 → CPU is served first (`grant_dma`=0), then DMA; `dma_q` is captured from the second transaction.
- CPU_PRIORITY=1, STARVE_LIMIT=4: DMA is pending while the CPU re-requests continuously → exactly 4 CPU grants, then 1 DMA grant, then CPU resumes.
- CPU_PRIORITY=0, both masters re-requesting continuously → grants alternate CPU, DMA, CPU, DMA; no master is granted twice in a row.
- `mu_init_done`=0 with a CPU write pending → `mu_start` stays 0 and `cpu_busy`=1; raising `mu_init_done` → issue two cycles later with `mu_we`=1 and the latched data.
- `reset` asserted during WAIT → next cycle all outputs are at reset values; a subsequent DMA request completes normally.
